// File: rtl/risc_v_pkg.sv
//------------------------------------------------------------------------------
// risc_v_pkg
//   Shared constants and types for the core and its instruction-memory loader.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package risc_v_pkg;

  localparam int         IMEM_ADDR_W = 8;
  localparam int         INSTR_W     = 32;
  localparam logic [7:0] START_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  // Instruction field bit positions used by the core decoder
  localparam int FLD_B        = 31;
  localparam int FLD_C        = 30;
  localparam int FLD_W        = 29;
  localparam int FLD_S        = 28;
  localparam int FLD_ALUOP_HI = 27;
  localparam int FLD_ALUOP_LO = 24;
  localparam int FLD_A1_HI    = 23;
  localparam int FLD_A1_LO    = 16;
  localparam int FLD_A2_HI    = 15;
  localparam int FLD_A2_LO    = 8;
  localparam int FLD_A3_HI    = 7;
  localparam int FLD_A3_LO    = 0;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
//------------------------------------------------------------------------------
// word_packer
//   Collects four stream bytes little-endian into one 32-bit instruction word.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module word_packer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // The completing byte is merged combinationally so the word is usable in the accept cycle
  assign word       = {byte_in, r_shift};
  assign word_ready = byte_en && (r_idx == 2'd3);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (clr) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (byte_en) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {byte_in, r_shift[23:8]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// imem_loader
//   Loads a framed byte-stream program image into instruction memory and holds
//   the core in reset until complete. Define IMEM_LOADER_CHECKSUM_EN for XOR check.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int         ADDR_W     = risc_v_pkg::IMEM_ADDR_W,
  parameter int         DATA_W     = risc_v_pkg::INSTR_W,
  parameter logic [7:0] START_BYTE = risc_v_pkg::START_BYTE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic              CORE_RST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W:0]   WORD_CNT
);

  import risc_v_pkg::*;

  loader_state_t     r_state;
  logic              r_ready;
  logic              r_we;
  logic              r_core_rst;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W:0]   r_len_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              r_err;
  logic [7:0]        r_xor;
`endif

  logic              w_fire;
  logic              w_start;
  logic              w_pack_en;
  logic              w_pack_clr;
  logic              w_word_done;
  logic [31:0]       w_word;

  assign w_fire     = IN_VALID & r_ready;
  assign w_start    = w_fire && (IN_DATA == START_BYTE);
  assign w_pack_en  = w_fire && (r_state == ST_DATA);
  assign w_pack_clr = w_fire && (r_state == ST_LEN);

  word_packer u_packer (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (w_pack_clr),
    .byte_en    (w_pack_en),
    .byte_in    (IN_DATA),
    .word       (w_word),
    .word_ready (w_word_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_core_rst  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_word_cnt  <= '0;
      r_len_words <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_err       <= 1'b0;
      r_xor       <= 8'd0;
`endif
    end else begin
      // The write slot occupies exactly one cycle, during which no byte is taken
      r_we    <= w_word_done;
      r_ready <= !w_word_done;
      if (w_word_done) begin
        r_wa       <= r_word_cnt[ADDR_W-1:0];
        r_wd       <= w_word;
        r_word_cnt <= r_word_cnt + (ADDR_W+1)'(1);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_pack_en) begin
        r_xor <= r_xor ^ IN_DATA;
      end
`endif

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_LEN;
            r_busy  <= 1'b1;
          end
        end
        ST_LEN: begin
          if (w_fire) begin
            r_state     <= ST_DATA;
            r_len_words <= (IN_DATA == 8'd0) ? (ADDR_W+1)'(256) : (ADDR_W+1)'(IN_DATA);
            r_word_cnt  <= '0;
            r_wa        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor       <= 8'd0;
`endif
          end
        end
        ST_DATA: begin
          // Word count already includes the word being written in this slot
          if (r_we && (r_word_cnt == r_len_words)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state    <= ST_CHK;
`else
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_core_rst <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_fire) begin
            r_busy <= 1'b0;
            if (IN_DATA == r_xor) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_core_rst <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        ST_DONE, ST_ERR: begin
          if (w_start) begin
            r_state    <= ST_LEN;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_core_rst <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_err      <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign IN_READY = r_ready;
  assign WE       = r_we;
  assign WA       = r_wa;
  assign WD       = r_wd;
  assign CORE_RST = r_core_rst;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign WORD_CNT = r_word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ERR      = r_err;
`else
  assign ERR      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// tb_imem_loader
//   Directed frames against a write-list model of the loader.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  IN_DATA = 8'd0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic        WE;
  logic [7:0]  WA;
  logic [31:0] WD;
  logic        CORE_RST;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [8:0]  WORD_CNT;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int exp_we_at   = -1;
  int we_seen     = 0;
  int nready_seen = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  body_q[$];

  imem_loader dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_DATA  (IN_DATA),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .WE       (WE),
    .WA       (WA),
    .WD       (WD),
    .CORE_RST (CORE_RST),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .WORD_CNT (WORD_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expected write list and write-slot timing
  always @(negedge CLK) begin
    if (RST) begin
      check("we_timing", {31'd0, WE}, {31'd0, (cyc == exp_we_at)});
      check("in_ready", {31'd0, IN_READY}, {31'd0, (cyc != exp_we_at)});
      if (WE) we_seen++;
      if (!IN_READY) nready_seen++;
      if (WE && exp_q.size() > 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, WA}, {24'd0, e[39:32]});
        check("wr_data", WD, e[31:0]);
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("err_tied", {31'd0, ERR}, 32'd0);
`endif
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit word_end);
    int n;
    n = 0;
    IN_DATA  = b;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && n < 20) begin
      n++;
      @(negedge CLK);
    end
    if (!IN_READY) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: byte %h not accepted within 20 cycles", b);
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    if (word_end) exp_we_at = cyc;
  endtask

  // LEN byte, body_q as data, optional checksum; expected writes queued up front
  task automatic send_body(input logic [7:0] len, input bit bad_chk);
    int nw;
    logic [7:0] x;
    nw = (len == 8'd0) ? 256 : int'(len);
    x  = 8'd0;
    for (int w = 0; w < nw; w++)
      exp_q.push_back({8'(w), body_q[4*w+3], body_q[4*w+2], body_q[4*w+1], body_q[4*w]});
    send_byte(len, 1'b0);
    for (int i = 0; i < 4*nw; i++) begin
      x = x ^ body_q[i];
      send_byte(body_q[i], (i % 4) == 3);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, 1'b0);
`else
    if (bad_chk) x = ~x;
`endif
    IN_VALID = 1'b0;
    body_q.delete();
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, IN_READY}, 32'd0);
    check({tag, "_we"},       {31'd0, WE},       32'd0);
    check({tag, "_wa"},       {24'd0, WA},       32'd0);
    check({tag, "_wd"},       WD,                32'd0);
    check({tag, "_core_rst"}, {31'd0, CORE_RST}, 32'd0);
    check({tag, "_busy"},     {31'd0, BUSY},     32'd0);
    check({tag, "_done"},     {31'd0, DONE},     32'd0);
    check({tag, "_err"},      {31'd0, ERR},      32'd0);
    check({tag, "_word_cnt"}, {23'd0, WORD_CNT}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("por");
    @(negedge CLK);
    #1 RST = 1'b1;

    // Reset in the middle of a data word
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    IN_VALID = 1'b0;
    check("busy_mid", {31'd0, BUSY}, 32'd1);
    #3 RST = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_we_at = -1;
    @(negedge CLK);
    #1 RST = 1'b1;
    send_byte(8'h11, 1'b0);
    idle(4);
    check("idle_drop_busy", {31'd0, BUSY}, 32'd0);
    check("idle_drop_done", {31'd0, DONE}, 32'd0);

    // Single-word frame
    body_q = '{8'h13, 8'h00, 8'hA0, 8'h00};
    send_byte(8'hA5, 1'b0);
    send_body(8'd1, 1'b0);
    idle(3);
    check("f1_done",     {31'd0, DONE},     32'd1);
    check("f1_core_rst", {31'd0, CORE_RST}, 32'd1);
    check("f1_busy",     {31'd0, BUSY},     32'd0);
    check("f1_word_cnt", {23'd0, WORD_CNT}, 32'd1);
    check("f1_wa",       {24'd0, WA},       32'd0);
    check("f1_wd",       WD,                32'h00A00013);

    // Back-to-back two-word frame, START_BYTE used as data
    we_seen     = 0;
    nready_seen = 0;
    body_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hA5, 8'h00, 8'h00, 8'hA5};
    send_byte(8'hA5, 1'b0);
    send_body(8'd2, 1'b0);
    idle(3);
    check("f2_we_count",    we_seen,            32'd2);
    check("f2_nready_cnt",  nready_seen,        32'd2);
    check("f2_word_cnt",    {23'd0, WORD_CNT},  32'd2);
    check("f2_wa",          {24'd0, WA},        32'd1);
    check("f2_wd",          WD,                 32'hA50000A5);

    // N=0: full 256-word image
    we_seen = 0;
    for (int j = 0; j < 1024; j++) body_q.push_back(8'(j * 7 + 3));
    send_byte(8'hA5, 1'b0);
    send_body(8'd0, 1'b0);
    idle(3);
    check("full_we_count", we_seen,           32'd256);
    check("full_word_cnt", {23'd0, WORD_CNT}, 32'd256);
    check("full_last_wa",  {24'd0, WA},       32'd255);
    check("full_last_wd",  WD,                32'hFCF5EEE7);
    check("full_done",     {31'd0, DONE},     32'd1);

    // Restart from DONE
    send_byte(8'hA5, 1'b0);
    check("restart_core_rst", {31'd0, CORE_RST}, 32'd0);
    check("restart_busy",     {31'd0, BUSY},     32'd1);
    check("restart_done",     {31'd0, DONE},     32'd0);
    body_q = '{8'h44, 8'h33, 8'h22, 8'h11};
    send_body(8'd1, 1'b0);
    idle(3);
    check("restart_word_cnt", {23'd0, WORD_CNT}, 32'd1);
    check("restart_wa",       {24'd0, WA},       32'd0);
    check("restart_wd",       WD,                32'h11223344);
    check("restart_core_up",  {31'd0, CORE_RST}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    body_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    send_byte(8'hA5, 1'b0);
    send_body(8'd1, 1'b0);
    idle(3);
    check("chk_ok_done",     {31'd0, DONE},     32'd1);
    check("chk_ok_err",      {31'd0, ERR},      32'd0);
    check("chk_ok_core_rst", {31'd0, CORE_RST}, 32'd1);
    check("chk_ok_wd",       WD,                32'h08040201);
    body_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    send_byte(8'hA5, 1'b0);
    send_body(8'd1, 1'b1);
    idle(3);
    check("chk_bad_err",      {31'd0, ERR},      32'd1);
    check("chk_bad_core_rst", {31'd0, CORE_RST}, 32'd0);
    check("chk_bad_done",     {31'd0, DONE},     32'd0);
    check("chk_bad_busy",     {31'd0, BUSY},     32'd0);
    send_byte(8'hA5, 1'b0);
    IN_VALID = 1'b0;
    check("chk_err_clear", {31'd0, ERR},  32'd0);
    check("chk_err_busy",  {31'd0, BUSY}, 32'd1);
    idle(2);
`endif

    check("writes_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
